// File: rtl/next_hop_lookup_if.sv
// next_hop_lookup_if: lookup request/response, host write and RAM port bundle
interface next_hop_lookup_if #(parameter int TAG_W = 8);
  logic             req_valid;
  logic             req_ready;
  logic [10:0]      req_index;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic             resp_hit;
  logic [TAG_W-1:0] resp_tag;
  logic             host_wr_valid;
  logic             host_wr_ready;
  logic [10:0]      host_addr;
  logic [3:0]       host_we;
  logic [31:0]      host_wdata;
  logic [10:0]      ram_addr;
  logic [31:0]      ram_din;
  logic [3:0]       ram_we;
  logic             ram_en;
  logic [31:0]      ram_dout;
  logic [15:0]      stat_lookups;
  logic [15:0]      stat_misses;
  modport slave (
    input  req_valid, req_index, req_tag, resp_ready,
    input  host_wr_valid, host_addr, host_we, host_wdata, ram_dout,
    output req_ready, resp_valid, resp_data, resp_hit, resp_tag, host_wr_ready,
    output ram_addr, ram_din, ram_we, ram_en, stat_lookups, stat_misses
  );
  modport master (
    output req_valid, req_index, req_tag, resp_ready,
    output host_wr_valid, host_addr, host_we, host_wdata, ram_dout,
    input  req_ready, resp_valid, resp_data, resp_hit, resp_tag, host_wr_ready,
    input  ram_addr, ram_din, ram_we, ram_en, stat_lookups, stat_misses
  );
endinterface

// File: rtl/next_hop_lookup.sv
// next_hop_lookup: 2048x32 next-hop table lookup FSM with host writes; NEXT_HOP_LOOKUP_CACHE_EN adds a one-entry result cache
module next_hop_lookup #(
  parameter int TAG_W = 8
) (
  input logic            clk,
  input logic            reset,
  next_hop_lookup_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, CAP, RESP} state_t;
  state_t           r_state, w_next;
  logic [10:0]      r_index;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_data;
  logic             r_hit;
  logic [15:0]      r_lookups, r_misses;
  logic             w_idle, w_wr, w_acc, w_done, w_chit;
  logic [31:0]      w_c_data;
`ifdef NEXT_HOP_LOOKUP_CACHE_EN
  logic [10:0]      r_c_index;
  logic [31:0]      r_c_data;
  logic             r_c_valid;
  assign w_chit   = r_c_valid && bus.req_index == r_c_index;
  assign w_c_data = r_c_data;
  // filled on every table read; any host write to the cached word invalidates it
  always_ff @(posedge clk) begin
    if (reset) r_c_valid <= 1'b0;
    else if (r_state == CAP) begin
      r_c_valid <= 1'b1;
      r_c_index <= r_index;
      r_c_data  <= bus.ram_dout;
    end else if (w_wr && bus.host_addr == r_c_index) r_c_valid <= 1'b0;
  end
`else
  assign w_chit   = 1'b0;
  assign w_c_data = '0;
`endif
  assign w_idle            = r_state == IDLE;
  assign w_wr              = w_idle && bus.host_wr_valid;
  assign w_acc             = bus.req_valid && bus.req_ready;
  assign w_done            = r_state == RESP && bus.resp_ready;
  assign bus.host_wr_ready = w_idle;
  assign bus.req_ready     = w_idle && !bus.host_wr_valid;
  assign bus.resp_valid    = r_state == RESP;
  assign bus.resp_data     = r_data;
  assign bus.resp_hit      = r_hit;
  assign bus.resp_tag      = r_tag;
  assign bus.stat_lookups  = r_lookups;
  assign bus.stat_misses   = r_misses;
  // RAM is held idle while reset is asserted so a pending host write cannot land
  assign bus.ram_en        = !reset && (w_wr || r_state == RD);
  assign bus.ram_we        = (!reset && w_wr) ? bus.host_we : 4'h0;
  assign bus.ram_addr      = w_wr ? bus.host_addr : r_index;
  assign bus.ram_din       = bus.host_wdata;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? (w_chit ? RESP : RD) : IDLE;
      RD:      w_next = CAP;
      CAP:     w_next = RESP;
      RESP:    w_next = bus.resp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_index   <= '0;
      r_tag     <= '0;
      r_data    <= '0;
      r_hit     <= 1'b0;
      r_lookups <= '0;
      r_misses  <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_index <= bus.req_index;
        r_tag   <= bus.req_tag;
      end
      if (r_state == CAP) begin
        r_data <= bus.ram_dout;
        r_hit  <= bus.ram_dout[31];
      end else if (w_acc && w_chit) begin
        r_data <= w_c_data;
        r_hit  <= w_c_data[31];
      end
      if (w_done && r_lookups != 16'hFFFF) r_lookups <= r_lookups + 16'd1;
      if (w_done && !r_hit && r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
    end
  end
endmodule

// File: tb/tb_next_hop_lookup.sv
// tb_next_hop_lookup: randomized self-checking bench with a table/cache/counter reference model
module tb_next_hop_lookup;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  next_hop_lookup_if #(.TAG_W(8)) bus ();
  next_hop_lookup #(.TAG_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] ram [2048] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.ram_en) begin
      bus.ram_dout <= ram[bus.ram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) ram[bus.ram_addr][b*8 +: 8] <= bus.ram_din[b*8 +: 8];
    end
  end
  logic [31:0] ref_mem [2048] = '{default: 32'h0};
  int          ref_lookups, ref_misses;
  logic        c_valid;
  logic [10:0] c_idx;
  int          checks, errors;

  function automatic int exp_lat(input logic [10:0] idx);
`ifdef NEXT_HOP_LOOKUP_CACHE_EN
    return (c_valid && c_idx == idx) ? 1 : 3;
`else
    return 3;
`endif
  endfunction

  function automatic void model_write(input logic [10:0] a, input logic [3:0] we, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (we[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    if (c_valid && c_idx == a) c_valid = 1'b0;
  endfunction

  function automatic void model_resp(input logic [10:0] idx);
    if (ref_lookups < 65535) ref_lookups++;
    if (!ref_mem[idx][31] && ref_misses < 65535) ref_misses++;
    c_valid = 1'b1;
    c_idx   = idx;
  endfunction

  task automatic host_write(input logic [10:0] a, input logic [3:0] we, input logic [31:0] d);
    bus.host_wr_valid = 1'b1;
    bus.host_addr     = a;
    bus.host_we       = we;
    bus.host_wdata    = d;
    @(negedge clk);
    bus.host_wr_valid = 1'b0;
    bus.host_we       = 4'h0;
    model_write(a, we, d);
  endtask

  task automatic lookup(input logic [10:0] idx, input logic [7:0] tag, input int hold,
                        output int lat, output logic [31:0] data, output logic hit, output logic [7:0] tg);
    int n;
    bus.req_valid = 1'b1;
    bus.req_index = idx;
    bus.req_tag   = tag;
    #1;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    data = bus.resp_data;
    hit  = bus.resp_hit;
    tg   = bus.resp_tag;
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    model_resp(idx);
  endtask

  task automatic test_reset;
    @(negedge clk);
    bus.host_wr_valid = 1'b1;
    bus.host_addr     = 11'h005;
    bus.host_we       = 4'hF;
    bus.host_wdata    = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got %b exp 0", bus.ram_en); end
    checks++; if (bus.ram_we !== 4'h0) begin errors++; $display("FAIL reset_ram_we got %h exp 0", bus.ram_we); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.host_wr_valid = 1'b0;
    bus.host_we = 4'h0;
    ref_lookups = 0; ref_misses = 0; c_valid = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data got %h exp 0", bus.resp_data); end
    checks++; if (bus.resp_hit !== 1'b0 || bus.resp_tag !== 8'h0) begin errors++; $display("FAIL reset_hit_tag got %b/%h exp 0/00", bus.resp_hit, bus.resp_tag); end
    checks++; if (bus.stat_lookups !== 16'h0 || bus.stat_misses !== 16'h0) begin errors++; $display("FAIL reset_stats got %h/%h exp 0/0", bus.stat_lookups, bus.stat_misses); end
    checks++; if (bus.req_ready !== 1'b1 || bus.host_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b/%b exp 1/1", bus.req_ready, bus.host_wr_ready); end
  endtask

  task automatic test_write_lookup;
    int lat, el; logic [31:0] d; logic h; logic [7:0] t;
    host_write(11'h012, 4'hF, 32'h8000_0A05);
    el = exp_lat(11'h012);
    lookup(11'h012, 8'h3C, 0, lat, d, h, t);
    checks++; if (lat !== el) begin errors++; $display("FAIL wl_latency got %0d exp %0d", lat, el); end
    checks++; if (d !== 32'h8000_0A05) begin errors++; $display("FAIL wl_data got %h exp 80000a05", d); end
    checks++; if (h !== 1'b1 || t !== 8'h3C) begin errors++; $display("FAIL wl_hit_tag got %b/%h exp 1/3c", h, t); end
    checks++; if (bus.stat_lookups !== 16'(ref_lookups)) begin errors++; $display("FAIL wl_lookups got %0d exp %0d", bus.stat_lookups, ref_lookups); end
  endtask

  task automatic test_miss;
    int lat; logic [31:0] d; logic h; logic [7:0] t;
    host_write(11'h100, 4'hF, 32'h0);
    lookup(11'h100, 8'h11, 1, lat, d, h, t);
    checks++; if (h !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL miss_resp got %b/%h exp 0/0", h, d); end
    checks++; if (bus.stat_misses !== 16'(ref_misses)) begin errors++; $display("FAIL miss_count got %0d exp %0d", bus.stat_misses, ref_misses); end
    checks++; if (bus.stat_lookups !== 16'(ref_lookups)) begin errors++; $display("FAIL miss_lookups got %0d exp %0d", bus.stat_lookups, ref_lookups); end
  endtask

  task automatic test_priority;
    int lat, el; logic [31:0] d; logic h; logic [7:0] t;
    bus.host_wr_valid = 1'b1; bus.host_addr = 11'h0AB; bus.host_we = 4'h3; bus.host_wdata = 32'h1234_5678;
    bus.req_valid = 1'b1; bus.req_index = 11'h0AB; bus.req_tag = 8'h55;
    #1;
    checks++; if (bus.req_ready !== 1'b0 || bus.host_wr_ready !== 1'b1) begin errors++; $display("FAIL prio_ready got %b/%b exp 0/1", bus.req_ready, bus.host_wr_ready); end
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 4'h3 || bus.ram_addr !== 11'h0AB) begin errors++; $display("FAIL prio_ram got %b/%h/%h exp 1/3/0ab", bus.ram_en, bus.ram_we, bus.ram_addr); end
    checks++; if (bus.ram_din !== 32'h1234_5678) begin errors++; $display("FAIL prio_din got %h exp 12345678", bus.ram_din); end
    @(negedge clk);
    bus.host_wr_valid = 1'b0; bus.host_we = 4'h0;
    model_write(11'h0AB, 4'h3, 32'h1234_5678);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL prio_next_ready got %b exp 1", bus.req_ready); end
    el = exp_lat(11'h0AB);
    lookup(11'h0AB, 8'h55, 0, lat, d, h, t);
    checks++; if (lat !== el || d !== ref_mem[11'h0AB]) begin errors++; $display("FAIL prio_lookup got %0d/%h exp %0d/%h", lat, d, el, ref_mem[11'h0AB]); end
  endtask

  task automatic test_backpressure;
    int lat, el; logic [31:0] ed;
    ed = ref_mem[11'h012];
    el = exp_lat(11'h012);
    bus.req_valid = 1'b1; bus.req_index = 11'h012; bus.req_tag = 8'h77;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin @(negedge clk); lat++; end
    checks++; if (lat !== el) begin errors++; $display("FAIL bp_latency got %0d exp %0d", lat, el); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== ed || bus.resp_tag !== 8'h77 || bus.resp_hit !== ed[31] || bus.req_ready !== 1'b0 || bus.ram_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v%b d%h t%h h%b rr%b en%b exp v1 d%h t77 h%b rr0 en0", i, bus.resp_valid, bus.resp_data, bus.resp_tag, bus.resp_hit, bus.req_ready, bus.ram_en, ed, ed[31]);
      end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    model_resp(11'h012);
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v%b rr%b exp v0 rr1", bus.resp_valid, bus.req_ready); end
    checks++; if (bus.stat_lookups !== 16'(ref_lookups)) begin errors++; $display("FAIL bp_lookups got %0d exp %0d", bus.stat_lookups, ref_lookups); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] d; logic h; logic [7:0] t;
    host_write(11'h200, 4'hF, 32'h8000_1111);
    bus.req_valid = 1'b1; bus.req_index = 11'h200; bus.req_tag = 8'h99;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.ram_en !== 1'b0 || bus.ram_we !== 4'h0) begin errors++; $display("FAIL rm_ram got %b/%h exp 0/0", bus.ram_en, bus.ram_we); end
    @(negedge clk);
    reset = 1'b0;
    ref_lookups = 0; ref_misses = 0; c_valid = 1'b0;
    #1;
    checks++; if (bus.resp_data !== 32'h0 || bus.resp_hit !== 1'b0 || bus.resp_tag !== 8'h0) begin errors++; $display("FAIL rm_resp got %h/%b/%h exp 0/0/00", bus.resp_data, bus.resp_hit, bus.resp_tag); end
    checks++; if (bus.stat_lookups !== 16'h0 || bus.stat_misses !== 16'h0) begin errors++; $display("FAIL rm_stats got %0d/%0d exp 0/0", bus.stat_lookups, bus.stat_misses); end
    h = 1'b0;
    repeat (4) begin @(negedge clk); h = h | bus.resp_valid; end
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL rm_no_resp got %b exp 0", h); end
    lookup(11'h200, 8'h9A, 0, lat, d, h, t);
    checks++; if (lat !== 3 || d !== 32'h8000_1111 || t !== 8'h9A) begin errors++; $display("FAIL rm_after got %0d/%h/%h exp 3/80001111/9a", lat, d, t); end
  endtask

`ifdef NEXT_HOP_LOOKUP_CACHE_EN
  task automatic test_cache;
    int lat; logic [31:0] d; logic h; logic [7:0] t;
    lookup(11'h012, 8'h01, 0, lat, d, h, t);
    lookup(11'h012, 8'h02, 0, lat, d, h, t);
    checks++; if (lat !== 1 || d !== ref_mem[11'h012] || t !== 8'h02) begin errors++; $display("FAIL cache_hit got %0d/%h/%h exp 1/%h/02", lat, d, t, ref_mem[11'h012]); end
    host_write(11'h012, 4'hF, 32'h8000_0B07);
    lookup(11'h012, 8'h03, 0, lat, d, h, t);
    checks++; if (lat !== 3 || d !== 32'h8000_0B07) begin errors++; $display("FAIL cache_inval got %0d/%h exp 3/80000b07", lat, d); end
  endtask
`endif

  task automatic test_random;
    int lat, el; logic [31:0] d, ed; logic h; logic [7:0] t, tag; logic [10:0] idx;
    for (int i = 0; i < 60; i++) begin
      idx = 11'h300 + 11'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) host_write(idx, 4'($urandom_range(1, 15)), $urandom);
      else begin
        tag = 8'($urandom);
        el  = exp_lat(idx);
        ed  = ref_mem[idx];
        lookup(idx, tag, $urandom_range(0, 3), lat, d, h, t);
        checks++;
        if (lat !== el || d !== ed || h !== ed[31] || t !== tag || bus.stat_lookups !== 16'(ref_lookups) || bus.stat_misses !== 16'(ref_misses)) begin
          errors++;
          $display("FAIL rand_lookup idx %h got lat%0d d%h h%b t%h L%0d M%0d exp lat%0d d%h h%b t%h L%0d M%0d", idx, lat, d, h, t, bus.stat_lookups, bus.stat_misses, el, ed, ed[31], tag, ref_lookups, ref_misses);
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; ref_lookups = 0; ref_misses = 0; c_valid = 1'b0; c_idx = '0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_index = '0; bus.req_tag = '0; bus.resp_ready = 1'b0;
    bus.host_wr_valid = 1'b0; bus.host_addr = '0; bus.host_we = 4'h0; bus.host_wdata = '0;
    test_reset;
    test_write_lookup;
    test_miss;
    test_priority;
    test_backpressure;
    test_reset_mid;
`ifdef NEXT_HOP_LOOKUP_CACHE_EN
    test_cache;
`endif
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
